// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct fields, ALU op codes,
// stall FSM states and the ID→EX bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic {RUN, STALL} stall_state_t;

  typedef struct packed {
    logic [3:0]  op_val;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        jump_instruction;
    logic        signed_unsigned_n;
    logic [4:0]  rd_addr;
    logic        rd_wr_en;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [31:0] link_value;
    logic [31:0] branch_target;
    logic        valid;
    logic        illegal;
  } id_ex_t;

  function automatic logic [3:0] alu_op(logic [2:0] f3, logic alt);
    logic [3:0] op;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// ALU operation bundle from ID to EX.
// master = ID (producer), slave = EX (consumer).
interface instr_decode_if #(
  parameter int XLEN = 32
);
  logic [3:0]      op_val;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            jump_instruction;
  logic            signed_unsigned_n;
  logic [4:0]      rd_addr;
  logic            rd_wr_en;
  logic            is_load;
  logic            is_store;
  logic            is_branch;
  logic [2:0]      funct3_out;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] link_value;
  logic [XLEN-1:0] branch_target;
  logic            valid_out;
  logic            illegal_instr;

  modport master (
    output op_val, operand_a, operand_b, jump_instruction,
    output signed_unsigned_n, rd_addr, rd_wr_en,
    output is_load, is_store, is_branch, funct3_out,
    output store_data, link_value, branch_target,
    output valid_out, illegal_instr
  );

  modport slave (
    input op_val, operand_a, operand_b, jump_instruction,
    input signed_unsigned_n, rd_addr, rd_wr_en,
    input is_load, is_store, is_branch, funct3_out,
    input store_data, link_value, branch_target,
    input valid_out, illegal_instr
  );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate extraction, all sign-extended from instr[31].
module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
endmodule

// File: rtl/instr_decode.sv
// ID stage: decode, operand forwarding, load-use stall,
// registered ALU bundle.
module instr_decode
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            flush,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      mem_rd,
  input  logic            ex_wr_en,
  input  logic            mem_wr_en,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] mem_result,
  output logic            stall_out,
  instr_decode_if.master  alu
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        use1, use2, hit1, hit2, ex_raw, mem_raw;
  logic        stall_req, ill, wr;
  id_ex_t      d, q;
  stall_state_t state_q, state_d;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rd       = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  imm_gen u_imm (
    .instr (instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  function automatic logic [31:0] fwd(logic [4:0] rs,
                                      logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (FWD_EN && ex_wr_en && ex_rd == rs && !ex_is_load)
      return ex_result;
    if (FWD_EN && mem_wr_en && mem_rd == rs)
      return mem_result;
    return rf;
  endfunction

  // Source operands after the forwarding muxes
  always_comb begin
    rs1_val = fwd(rs1_addr, rs1_data);
    rs2_val = fwd(rs2_addr, rs2_data);
  end

  // Which source registers this opcode reads
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR, OPC_LOAD: use1 = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection and stall request
  always_comb begin
    hit1    = use1 && rs1_addr != 5'd0;
    hit2    = use2 && rs2_addr != 5'd0;
    ex_raw  = ex_rd != 5'd0 &&
              ((hit1 && rs1_addr == ex_rd) ||
               (hit2 && rs2_addr == ex_rd));
    mem_raw = mem_wr_en && mem_rd != 5'd0 &&
              ((hit1 && rs1_addr == mem_rd) ||
               (hit2 && rs2_addr == mem_rd));
    if (FWD_EN)
      stall_req = instr_valid && !flush && state_q == RUN &&
                  ex_is_load && ex_raw;
    else
      stall_req = instr_valid && !flush &&
                  (((ex_wr_en || ex_is_load) && ex_raw) || mem_raw);
  end

  assign stall_out = stall_req;

  // Stall FSM next state
  always_comb begin
    state_d = RUN;
    if (!flush && stall_req) state_d = STALL;
  end

  // Decode into the next bundle; bubble when nothing issues
  always_comb begin
    d   = '0;
    ill = 1'b0;
    wr  = 1'b0;
    if (instr_valid && !flush && !stall_req) begin
      d.valid         = 1'b1;
      d.rd_addr       = rd;
      d.funct3        = f3;
      d.store_data    = rs2_val;
      d.link_value    = pc + 32'd4;
      d.branch_target = pc + imm_b;
      unique case (opc)
        OPC_OP: begin
          d.operand_a = rs1_val;
          d.operand_b = rs2_val;
          d.op_val    = alu_op(f3, f7[5]);
          d.signed_unsigned_n = f3 == F3_SLT;
          wr  = 1'b1;
          ill = !(f7 == F7_BASE ||
                  (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
        end
        OPC_OP_IMM: begin
          d.operand_a = rs1_val;
          d.operand_b = imm_i;
          d.op_val    = alu_op(f3, f3 == F3_SR && f7[5]);
          d.signed_unsigned_n = f3 == F3_SLT;
          wr = 1'b1;
          if (f3 == F3_SLL || f3 == F3_SR)
            d.operand_b = {27'd0, instr[24:20]};
          if (f3 == F3_SLL) ill = f7 != F7_BASE;
          if (f3 == F3_SR)
            ill = !(f7 == F7_BASE || f7 == F7_ALT);
        end
        OPC_LUI: begin
          d.operand_b = imm_u;
          d.op_val    = ALU_ADD;
          wr = 1'b1;
        end
        OPC_AUIPC: begin
          d.operand_a = pc;
          d.operand_b = imm_u;
          d.op_val    = ALU_ADD;
          wr = 1'b1;
        end
        OPC_JAL: begin
          d.operand_a = pc;
          d.operand_b = imm_j;
          d.op_val    = ALU_ADD;
          d.jump_instruction = 1'b1;
          wr = 1'b1;
        end
        OPC_JALR: begin
          d.operand_a = rs1_val;
          d.operand_b = imm_i;
          d.op_val    = ALU_ADD;
          d.jump_instruction = 1'b1;
          wr  = 1'b1;
          ill = f3 != 3'b000;
        end
        OPC_LOAD: begin
          d.operand_a = rs1_val;
          d.operand_b = imm_i;
          d.op_val    = ALU_ADD;
          d.is_load   = 1'b1;
          wr  = 1'b1;
          ill = f3 == 3'b011 || f3[2:1] == 2'b11;
        end
        OPC_STORE: begin
          d.operand_a = rs1_val;
          d.operand_b = imm_s;
          d.op_val    = ALU_ADD;
          d.is_store  = 1'b1;
          ill = f3[2] || f3 == 3'b011;
        end
        OPC_BRANCH: begin
          d.operand_a = rs1_val;
          d.operand_b = rs2_val;
          d.is_branch = 1'b1;
          unique case (f3[2:1])
            2'b00:   d.op_val = ALU_SUB;
            2'b10:   d.op_val = ALU_SLT;
            2'b11:   d.op_val = ALU_SLTU;
            default: ill = 1'b1;
          endcase
          d.signed_unsigned_n = f3[2:1] == 2'b10;
        end
        default: ill = 1'b1;
      endcase
      if (ill) begin
        d.op_val            = ALU_NOP;
        d.jump_instruction  = 1'b0;
        d.signed_unsigned_n = 1'b0;
        d.is_load           = 1'b0;
        d.is_store          = 1'b0;
        d.is_branch         = 1'b0;
        wr                  = 1'b0;
      end
      d.illegal  = ill;
      d.rd_wr_en = wr && rd != 5'd0;
    end
  end

  // State and bundle registers; halt freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      q       <= '0;
    end else if (!halt) begin
      state_q <= state_d;
      q       <= d;
    end
  end

  assign alu.op_val            = q.op_val;
  assign alu.operand_a         = q.operand_a;
  assign alu.operand_b         = q.operand_b;
  assign alu.jump_instruction  = q.jump_instruction;
  assign alu.signed_unsigned_n = q.signed_unsigned_n;
  assign alu.rd_addr           = q.rd_addr;
  assign alu.rd_wr_en          = q.rd_wr_en;
  assign alu.is_load           = q.is_load;
  assign alu.is_store          = q.is_store;
  assign alu.is_branch         = q.is_branch;
  assign alu.funct3_out        = q.funct3;
  assign alu.store_data        = q.store_data;
  assign alu.link_value        = q.link_value;
  assign alu.branch_target     = q.branch_target;
  assign alu.valid_out         = q.valid;
  assign alu.illegal_instr     = q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for the ID stage: decode, forwarding,
// load-use stall, halt, flush and reset.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst, halt, flush, instr_valid;
  logic [31:0] instr, pc;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd, mem_rd;
  logic [31:0] rs1_data, rs2_data, ex_result, mem_result;
  logic        ex_wr_en, mem_wr_en, ex_is_load, stall_out;
  logic [31:0] rf [32];
  int          n_chk = 0;
  int          n_fail = 0;

  instr_decode_if alu ();

  instr_decode dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .ex_rd       (ex_rd),
    .mem_rd      (mem_rd),
    .ex_wr_en    (ex_wr_en),
    .mem_wr_en   (mem_wr_en),
    .ex_is_load  (ex_is_load),
    .ex_result   (ex_result),
    .mem_result  (mem_result),
    .stall_out   (stall_out),
    .alu         (alu)
  );

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; halt = 0; flush = 0; instr_valid = 0;
    instr = 32'h0000_0013; pc = 0;
    ex_rd = 0; mem_rd = 0; ex_wr_en = 0; mem_wr_en = 0;
    ex_is_load = 0; ex_result = 0; mem_result = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step();
    n_chk++; if (alu.op_val !== 4'b0000) begin n_fail++; $display("FAIL reset_op got %h exp 0", alu.op_val); end
    n_chk++; if (alu.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", alu.valid_out); end
    n_chk++; if (alu.operand_b !== 32'h0) begin n_fail++; $display("FAIL reset_b got %h exp 0", alu.operand_b); end
    rst = 0;
  endtask

  task automatic test_addi();
    idle(); instr_valid = 1; instr = 32'hFFF0_0293;
    step();
    n_chk++; if (alu.op_val !== 4'b0001) begin n_fail++; $display("FAIL addi_op got %h exp 1", alu.op_val); end
    n_chk++; if (alu.operand_a !== 32'h0) begin n_fail++; $display("FAIL addi_a got %h exp 0", alu.operand_a); end
    n_chk++; if (alu.operand_b !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_b got %h exp ffffffff", alu.operand_b); end
    n_chk++; if (alu.rd_addr !== 5'd5 || alu.rd_wr_en !== 1'b1) begin n_fail++; $display("FAIL addi_rd got %0d/%b exp 5/1", alu.rd_addr, alu.rd_wr_en); end
    n_chk++; if (alu.valid_out !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", alu.valid_out); end
  endtask

  task automatic test_alu();
    idle(); instr_valid = 1; rf[1] = 32'd10; rf[2] = 32'd3;
    instr = 32'h4020_81B3;
    step();
    n_chk++; if (alu.op_val !== 4'b0010) begin n_fail++; $display("FAIL sub_op got %h exp 2", alu.op_val); end
    n_chk++; if (alu.operand_a !== 32'd10 || alu.operand_b !== 32'd3) begin n_fail++; $display("FAIL sub_ops got %h/%h exp a/3", alu.operand_a, alu.operand_b); end
    instr = 32'h4030_D093;
    step();
    n_chk++; if (alu.op_val !== 4'b1001) begin n_fail++; $display("FAIL srai_op got %h exp 9", alu.op_val); end
    n_chk++; if (alu.operand_b !== 32'd3) begin n_fail++; $display("FAIL srai_shamt got %h exp 3", alu.operand_b); end
    instr = 32'h0020_A233;
    step();
    n_chk++; if (alu.op_val !== 4'b0011 || alu.signed_unsigned_n !== 1'b1) begin n_fail++; $display("FAIL slt got %h/%b exp 3/1", alu.op_val, alu.signed_unsigned_n); end
  endtask

  task automatic test_branch();
    idle(); instr_valid = 1; pc = 32'h200;
    rf[1] = 32'd10; rf[2] = 32'd3; instr = 32'h0020_C863;
    step();
    n_chk++; if (alu.op_val !== 4'b0011 || alu.signed_unsigned_n !== 1'b1) begin n_fail++; $display("FAIL blt_op got %h/%b exp 3/1", alu.op_val, alu.signed_unsigned_n); end
    n_chk++; if (alu.branch_target !== 32'h210) begin n_fail++; $display("FAIL blt_target got %h exp 210", alu.branch_target); end
    n_chk++; if (alu.is_branch !== 1'b1 || alu.rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL blt_flags got %b/%b exp 1/0", alu.is_branch, alu.rd_wr_en); end
    n_chk++; if (alu.operand_b !== 32'd3) begin n_fail++; $display("FAIL blt_b got %h exp 3", alu.operand_b); end
  endtask

  task automatic test_jal();
    idle(); instr_valid = 1; pc = 32'h100; instr = 32'h0080_00EF;
    step();
    n_chk++; if (alu.operand_a !== 32'h100 || alu.operand_b !== 32'd8) begin n_fail++; $display("FAIL jal_ops got %h/%h exp 100/8", alu.operand_a, alu.operand_b); end
    n_chk++; if (alu.jump_instruction !== 1'b1) begin n_fail++; $display("FAIL jal_jump got %b exp 1", alu.jump_instruction); end
    n_chk++; if (alu.link_value !== 32'h104) begin n_fail++; $display("FAIL jal_link got %h exp 104", alu.link_value); end
    n_chk++; if (alu.op_val !== 4'b0001) begin n_fail++; $display("FAIL jal_op got %h exp 1", alu.op_val); end
  endtask

  task automatic test_illegal();
    idle(); instr_valid = 1; instr = 32'hFFFF_FFFF;
    step();
    n_chk++; if (alu.illegal_instr !== 1'b1 || alu.valid_out !== 1'b1) begin n_fail++; $display("FAIL ill_flags got %b/%b exp 1/1", alu.illegal_instr, alu.valid_out); end
    n_chk++; if (alu.op_val !== 4'b0000 || alu.rd_wr_en !== 1'b0) begin n_fail++; $display("FAIL ill_op got %h/%b exp 0/0", alu.op_val, alu.rd_wr_en); end
  endtask

  task automatic test_forward();
    idle(); instr_valid = 1; rf[1] = 32'h1; instr = 32'h0000_8413;
    ex_rd = 1; ex_wr_en = 1; ex_result = 32'hDEAD_BEEF;
    mem_rd = 1; mem_wr_en = 1; mem_result = 32'h1234;
    step();
    n_chk++; if (alu.operand_a !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fwd_ex got %h exp deadbeef", alu.operand_a); end
    ex_wr_en = 0;
    step();
    n_chk++; if (alu.operand_a !== 32'h1234) begin n_fail++; $display("FAIL fwd_mem got %h exp 1234", alu.operand_a); end
    mem_wr_en = 0;
    step();
    n_chk++; if (alu.operand_a !== 32'h1) begin n_fail++; $display("FAIL fwd_rf got %h exp 1", alu.operand_a); end
    instr = 32'h0000_0413; ex_rd = 0; ex_wr_en = 1; mem_rd = 0; mem_wr_en = 1;
    step();
    n_chk++; if (alu.operand_a !== 32'h0) begin n_fail++; $display("FAIL fwd_x0 got %h exp 0", alu.operand_a); end
  endtask

  task automatic test_load_use();
    idle(); instr_valid = 1; rf[1] = 32'h40; rf[6] = 32'h6;
    instr = 32'h0000_A303;
    step();
    n_chk++; if (alu.is_load !== 1'b1 || alu.operand_a !== 32'h40) begin n_fail++; $display("FAIL lw got %b/%h exp 1/40", alu.is_load, alu.operand_a); end
    instr = 32'h0063_03B3;
    ex_rd = 6; ex_wr_en = 1; ex_is_load = 1; ex_result = 32'hBAD0_BAD0;
    #1;
    n_chk++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", stall_out); end
    step();
    n_chk++; if (alu.valid_out !== 1'b0 || alu.op_val !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble got %b/%h exp 0/0", alu.valid_out, alu.op_val); end
    ex_rd = 0; ex_wr_en = 0; ex_is_load = 0;
    mem_rd = 6; mem_wr_en = 1; mem_result = 32'h55;
    #1;
    n_chk++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall_out); end
    step();
    n_chk++; if (alu.operand_a !== 32'h55 || alu.operand_b !== 32'h55) begin n_fail++; $display("FAIL lu_ops got %h/%h exp 55/55", alu.operand_a, alu.operand_b); end
    n_chk++; if (alu.op_val !== 4'b0001 || alu.rd_addr !== 5'd7) begin n_fail++; $display("FAIL lu_op got %h/%0d exp 1/7", alu.op_val, alu.rd_addr); end
  endtask

  task automatic test_halt();
    idle(); instr_valid = 1; instr = 32'hFFF0_0293;
    step();
    halt = 1; instr = 32'h4020_81B3; rf[1] = 32'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (alu.op_val !== 4'b0001 || alu.operand_b !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL halt_hold%0d got %h/%h exp 1/ffffffff", i, alu.op_val, alu.operand_b); end
    end
    halt = 0;
    step();
    n_chk++; if (alu.op_val !== 4'b0010 || alu.operand_a !== 32'd9) begin n_fail++; $display("FAIL halt_resume got %h/%h exp 2/9", alu.op_val, alu.operand_a); end
  endtask

  task automatic test_halt_in_stall();
    idle(); instr_valid = 1; instr = 32'h0063_03B3;
    ex_rd = 6; ex_wr_en = 1; ex_is_load = 1;
    step();
    halt = 1; mem_rd = 6; mem_wr_en = 1; mem_result = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (stall_out !== 1'b0 || alu.valid_out !== 1'b0) begin n_fail++; $display("FAIL hstall_frozen%0d got %b/%b exp 0/0", i, stall_out, alu.valid_out); end
    end
    halt = 0;
    step();
    n_chk++; if (alu.valid_out !== 1'b1 || alu.operand_a !== 32'h77) begin n_fail++; $display("FAIL hstall_resume got %b/%h exp 1/77", alu.valid_out, alu.operand_a); end
  endtask

  task automatic test_flush();
    idle(); instr_valid = 1; instr = 32'hFFF0_0293;
    step();
    flush = 1; instr = 32'h0080_00EF;
    step();
    n_chk++; if (alu.valid_out !== 1'b0 || alu.op_val !== 4'b0000) begin n_fail++; $display("FAIL flush_bubble got %b/%h exp 0/0", alu.valid_out, alu.op_val); end
    n_chk++; if (alu.rd_wr_en !== 1'b0 || alu.jump_instruction !== 1'b0) begin n_fail++; $display("FAIL flush_flags got %b/%b exp 0/0", alu.rd_wr_en, alu.jump_instruction); end
  endtask

  task automatic test_reset_in_stall();
    idle(); instr_valid = 1; instr = 32'h0063_03B3;
    ex_rd = 6; ex_wr_en = 1; ex_is_load = 1;
    step();
    rst = 1;
    step();
    n_chk++; if (alu.valid_out !== 1'b0 || alu.op_val !== 4'b0000 || alu.link_value !== 32'h0) begin n_fail++; $display("FAIL rst_stall_out got %b/%h/%h exp 0/0/0", alu.valid_out, alu.op_val, alu.link_value); end
    rst = 0;
    #1;
    n_chk++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL rst_stall_run got %b exp 1", stall_out); end
    idle();
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    idle();
    test_reset();
    test_addi();
    test_alu();
    test_branch();
    test_jal();
    test_illegal();
    test_forward();
    test_load_use();
    test_halt();
    test_halt_in_stall();
    test_flush();
    test_reset_in_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
